// File: rtl/ipdom_pkg.sv
// ipdom_pkg: shared types and constants for the IPDOM split/join controller.
package ipdom_pkg;

  // Settle interval for a zero-latency stack; the registered-output stack adds one.
  localparam int IPDOM_SETTLE_MIN = 1;

  // Default geometry of the warp datapath.
  localparam int IPDOM_NUM_THREADS = 4;
  localparam int IPDOM_PC_BITS     = 30;
  localparam int IPDOM_STACK_DEPTH = 8;

  // Pointer width for a stack of n entries, never narrower than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IPDOM_PTRW = log2up(IPDOM_STACK_DEPTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } ipdom_state_e;

  typedef struct packed {
    logic [IPDOM_NUM_THREADS-1:0] tmask;
    logic [IPDOM_PC_BITS-1:0]     pc;
  } ipdom_entry_t;

  typedef struct packed {
    logic                         is_split;
    logic [IPDOM_NUM_THREADS-1:0] tmask;
    logic [IPDOM_NUM_THREADS-1:0] then_tmask;
    logic [IPDOM_NUM_THREADS-1:0] else_tmask;
    logic [IPDOM_PC_BITS-1:0]     else_pc;
    logic [IPDOM_PTRW-1:0]        join_ptr;
  } ipdom_req_t;

  typedef struct packed {
    logic                         valid;
    logic                         divergent;
    logic [IPDOM_NUM_THREADS-1:0] tmask;
    logic                         pc_valid;
    logic [IPDOM_PC_BITS-1:0]     pc;
    logic [IPDOM_PTRW-1:0]        sptr;
  } ipdom_rsp_t;

endpackage

// File: rtl/ipdom_branch_decode.sv
// ipdom_branch_decode: combinational split/join decision for one accepted request.
// Produces the stack push/pop strobes, the error strobes and the response fields.
module ipdom_branch_decode
  import ipdom_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int PTRW        = 3,
  parameter int ENTRYW      = NUM_THREADS + PC_BITS
) (
  input  logic                   accept,
  input  logic                   is_split,
  input  logic [NUM_THREADS-1:0] tmask,
  input  logic [NUM_THREADS-1:0] then_tmask,
  input  logic [NUM_THREADS-1:0] else_tmask,
  input  logic [PC_BITS-1:0]     else_pc,
  input  logic [PTRW-1:0]        join_ptr,
  input  logic [ENTRYW-1:0]      stk_d,
  input  logic                   stk_d_set,
  input  logic [PTRW-1:0]        stk_q_ptr,
  input  logic                   stk_empty,
  input  logic                   stk_full,
  output logic                   push,
  output logic                   pop,
  output logic                   ovf,
  output logic                   unf,
  output logic                   divergent,
  output logic [NUM_THREADS-1:0] rsp_tmask,
  output logic                   rsp_pc_valid,
  output logic [PC_BITS-1:0]     rsp_pc,
  output logic [ENTRYW-1:0]      stk_q0,
  output logic [ENTRYW-1:0]      stk_q1
);

  logic taken;
  logic not_taken;
  logic ptr_match;

  assign taken     = |then_tmask;
  assign not_taken = |else_tmask;
  assign ptr_match = (join_ptr == stk_q_ptr);

  // The restore entry keeps the pre-split mask; the else entry carries the deferred path.
  assign stk_q0 = {tmask, {PC_BITS{1'b0}}};
  assign stk_q1 = {else_tmask, else_pc};

  // Decide push/pop and the new mask/PC; strobes only fire for an accepted request.
  always_comb begin
    push         = 1'b0;
    pop          = 1'b0;
    ovf          = 1'b0;
    unf          = 1'b0;
    divergent    = 1'b0;
    rsp_tmask    = tmask;
    rsp_pc_valid = 1'b0;
    rsp_pc       = '0;
    if (is_split) begin
      if (taken && not_taken) begin
        rsp_tmask = then_tmask;
        if (stk_full) begin
          ovf = accept;
        end else begin
          push      = accept;
          divergent = 1'b1;
        end
      end else if (not_taken) begin
        rsp_tmask    = else_tmask;
        rsp_pc       = else_pc;
        rsp_pc_valid = 1'b1;
      end else if (taken) begin
        rsp_tmask = then_tmask;
      end
    end else if (!ptr_match) begin
      if (stk_empty) begin
        unf = accept;
      end else begin
        pop       = accept;
        rsp_tmask = stk_d[ENTRYW-1 -: NUM_THREADS];
        if (stk_d_set) begin
          rsp_pc_valid = 1'b1;
          rsp_pc       = stk_d[PC_BITS-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ipdom_branch_ctrl.sv
// ipdom_branch_ctrl: per-warp split/join controller driving one IPDOM divergence stack.
// Stack operations are followed by a settle interval that hides the stack read latency.
// Optional: define IPDOM_PERF_EN to build the divergence/redirect perf counters.
module ipdom_branch_ctrl
  import ipdom_pkg::*;
#(
  parameter int NUM_THREADS   = 4,
  parameter int PC_BITS       = 30,
  parameter int STACK_DEPTH   = 8,
  parameter int STACK_OUT_REG = 0,
  parameter int PTRW          = log2up(STACK_DEPTH),
  parameter int ENTRYW        = NUM_THREADS + PC_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_split,
  input  logic [NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_THREADS-1:0] req_then_tmask,
  input  logic [NUM_THREADS-1:0] req_else_tmask,
  input  logic [PC_BITS-1:0]     req_else_pc,
  input  logic [PTRW-1:0]        req_join_ptr,
  output logic                   rsp_valid,
  output logic                   rsp_divergent,
  output logic [NUM_THREADS-1:0] rsp_tmask,
  output logic                   rsp_pc_valid,
  output logic [PC_BITS-1:0]     rsp_pc,
  output logic [PTRW-1:0]        rsp_sptr,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [ENTRYW-1:0]      stk_q0,
  output logic [ENTRYW-1:0]      stk_q1,
  input  logic [ENTRYW-1:0]      stk_d,
  input  logic                   stk_d_set,
  input  logic [PTRW-1:0]        stk_q_ptr,
  input  logic                   stk_empty,
  input  logic                   stk_full,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic [31:0]            perf_dvg_cnt,
  output logic [31:0]            perf_redir_cnt
);

  typedef struct packed {
    logic                   valid;
    logic                   divergent;
    logic [NUM_THREADS-1:0] tmask;
    logic                   pc_valid;
    logic [PC_BITS-1:0]     pc;
    logic [PTRW-1:0]        sptr;
  } rsp_t;

  localparam logic [1:0] SETTLE_LOAD = 2'(IPDOM_SETTLE_MIN + STACK_OUT_REG);

  ipdom_state_e           state_q;
  ipdom_state_e           state_d;
  logic [1:0]             settle_q;
  logic [1:0]             settle_d;
  logic                   accept;
  logic                   dec_ovf;
  logic                   dec_unf;
  logic                   dec_divergent;
  logic [NUM_THREADS-1:0] dec_tmask;
  logic                   dec_pc_valid;
  logic [PC_BITS-1:0]     dec_pc;
  rsp_t                   rsp_d;
  rsp_t                   rsp_q;

  // A request arriving during reset is never accepted, so nothing reaches the stack.
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready & ~reset;

  ipdom_branch_decode #(
    .NUM_THREADS (NUM_THREADS),
    .PC_BITS     (PC_BITS),
    .PTRW        (PTRW),
    .ENTRYW      (ENTRYW)
  ) u_decode (
    .accept       (accept),
    .is_split     (req_is_split),
    .tmask        (req_tmask),
    .then_tmask   (req_then_tmask),
    .else_tmask   (req_else_tmask),
    .else_pc      (req_else_pc),
    .join_ptr     (req_join_ptr),
    .stk_d        (stk_d),
    .stk_d_set    (stk_d_set),
    .stk_q_ptr    (stk_q_ptr),
    .stk_empty    (stk_empty),
    .stk_full     (stk_full),
    .push         (stk_push),
    .pop          (stk_pop),
    .ovf          (dec_ovf),
    .unf          (dec_unf),
    .divergent    (dec_divergent),
    .rsp_tmask    (dec_tmask),
    .rsp_pc_valid (dec_pc_valid),
    .rsp_pc       (dec_pc),
    .stk_q0       (stk_q0),
    .stk_q1       (stk_q1)
  );

  // Next-state: any stack operation blocks new requests until the stack top has settled.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (stk_push || stk_pop) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 2'd1;
        if (settle_q <= 2'd1) begin
          state_d  = ST_IDLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = '0;
      end
    endcase
  end

  // State and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Response contents for the accepted request; all-zero in cycles with no acceptance.
  always_comb begin
    rsp_d = '0;
    if (accept) begin
      rsp_d.valid     = 1'b1;
      rsp_d.divergent = dec_divergent;
      rsp_d.tmask     = dec_tmask;
      rsp_d.pc_valid  = dec_pc_valid;
      rsp_d.pc        = dec_pc;
      rsp_d.sptr      = stk_q_ptr;
    end
  end

  // Response register: one-cycle pulse after acceptance, dropped by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_valid     = rsp_q.valid;
  assign rsp_divergent = rsp_q.divergent;
  assign rsp_tmask     = rsp_q.tmask;
  assign rsp_pc_valid  = rsp_q.pc_valid;
  assign rsp_pc        = rsp_q.pc;
  assign rsp_sptr      = rsp_q.sptr;

  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | dec_ovf;
      err_unf <= err_unf | dec_unf;
    end
  end

`ifdef IPDOM_PERF_EN
  logic [31:0] dvg_cnt_q;
  logic [31:0] redir_cnt_q;

  // Wrapping counters of divergent splits and of joins that redirect the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvg_cnt_q   <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (stk_push) begin
        dvg_cnt_q <= dvg_cnt_q + 32'd1;
      end
      if (stk_pop && dec_pc_valid) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign perf_dvg_cnt   = dvg_cnt_q;
  assign perf_redir_cnt = redir_cnt_q;
`else
  assign perf_dvg_cnt   = '0;
  assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_ipdom_branch_ctrl.sv
// tb_ipdom_branch_ctrl: table-driven and randomized checks of the split/join controller.
// Two instances share the request/stack inputs: one with a combinational stack read
// and one with a registered stack read, so both settle lengths are observed.
module tb_ipdom_branch_ctrl;
  import ipdom_pkg::*;

  typedef struct {
    string       name;
    logic        is_split;
    logic [3:0]  tmask;
    logic [3:0]  then_m;
    logic [3:0]  else_m;
    logic [29:0] else_pc;
    logic [2:0]  join_ptr;
    logic [33:0] stk_d;
    logic        d_set;
    logic [2:0]  q_ptr;
    logic        empty;
    logic        full;
    logic        e_push;
    logic        e_pop;
    logic [3:0]  e_tmask;
    logic        e_pcv;
    logic [29:0] e_pc;
    logic        e_div;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_is_split;
  logic [3:0]  req_tmask;
  logic [3:0]  req_then_tmask;
  logic [3:0]  req_else_tmask;
  logic [29:0] req_else_pc;
  logic [2:0]  req_join_ptr;
  logic [33:0] stk_d;
  logic        stk_d_set;
  logic [2:0]  stk_q_ptr;
  logic        stk_empty;
  logic        stk_full;

  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_divergent;
  logic [1:0][3:0]   rsp_tmask;
  logic [1:0]        rsp_pc_valid;
  logic [1:0][29:0]  rsp_pc;
  logic [1:0][2:0]   rsp_sptr;
  logic [1:0]        stk_push;
  logic [1:0]        stk_pop;
  logic [1:0][33:0]  stk_q0;
  logic [1:0][33:0]  stk_q1;
  logic [1:0]        err_ovf;
  logic [1:0]        err_unf;
  logic [1:0][31:0]  perf_dvg_cnt;
  logic [1:0][31:0]  perf_redir_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: sticky flags and event counts.
  bit exp_ovf = 0;
  bit exp_unf = 0;
  int exp_dvg = 0;
  int exp_redir = 0;

  vec_t table_v[8];

  ipdom_branch_ctrl #(.STACK_OUT_REG(0)) u_dut0 (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready[0]),
    .req_is_split   (req_is_split),
    .req_tmask      (req_tmask),
    .req_then_tmask (req_then_tmask),
    .req_else_tmask (req_else_tmask),
    .req_else_pc    (req_else_pc),
    .req_join_ptr   (req_join_ptr),
    .rsp_valid      (rsp_valid[0]),
    .rsp_divergent  (rsp_divergent[0]),
    .rsp_tmask      (rsp_tmask[0]),
    .rsp_pc_valid   (rsp_pc_valid[0]),
    .rsp_pc         (rsp_pc[0]),
    .rsp_sptr       (rsp_sptr[0]),
    .stk_push       (stk_push[0]),
    .stk_pop        (stk_pop[0]),
    .stk_q0         (stk_q0[0]),
    .stk_q1         (stk_q1[0]),
    .stk_d          (stk_d),
    .stk_d_set      (stk_d_set),
    .stk_q_ptr      (stk_q_ptr),
    .stk_empty      (stk_empty),
    .stk_full       (stk_full),
    .err_ovf        (err_ovf[0]),
    .err_unf        (err_unf[0]),
    .perf_dvg_cnt   (perf_dvg_cnt[0]),
    .perf_redir_cnt (perf_redir_cnt[0])
  );

  ipdom_branch_ctrl #(.STACK_OUT_REG(1)) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready[1]),
    .req_is_split   (req_is_split),
    .req_tmask      (req_tmask),
    .req_then_tmask (req_then_tmask),
    .req_else_tmask (req_else_tmask),
    .req_else_pc    (req_else_pc),
    .req_join_ptr   (req_join_ptr),
    .rsp_valid      (rsp_valid[1]),
    .rsp_divergent  (rsp_divergent[1]),
    .rsp_tmask      (rsp_tmask[1]),
    .rsp_pc_valid   (rsp_pc_valid[1]),
    .rsp_pc         (rsp_pc[1]),
    .rsp_sptr       (rsp_sptr[1]),
    .stk_push       (stk_push[1]),
    .stk_pop        (stk_pop[1]),
    .stk_q0         (stk_q0[1]),
    .stk_q1         (stk_q1[1]),
    .stk_d          (stk_d),
    .stk_d_set      (stk_d_set),
    .stk_q_ptr      (stk_q_ptr),
    .stk_empty      (stk_empty),
    .stk_full       (stk_full),
    .err_ovf        (err_ovf[1]),
    .err_unf        (err_unf[1]),
    .perf_dvg_cnt   (perf_dvg_cnt[1]),
    .perf_redir_cnt (perf_redir_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input bit s, input logic [3:0] tm, input logic [3:0] th,
                              input logic [3:0] el, input logic [29:0] pc, input logic [2:0] jp,
                              input logic [33:0] d, input bit ds, input logic [2:0] qp, input bit em,
                              input bit fu, input bit ep, input bit epop, input logic [3:0] et,
                              input bit epcv, input logic [29:0] epc, input bit ediv);
    vec_t v;
    v.name = n; v.is_split = s; v.tmask = tm; v.then_m = th; v.else_m = el; v.else_pc = pc;
    v.join_ptr = jp; v.stk_d = d; v.d_set = ds; v.q_ptr = qp; v.empty = em; v.full = fu;
    v.e_push = ep; v.e_pop = epop; v.e_tmask = et; v.e_pcv = epcv; v.e_pc = epc; v.e_div = ediv;
    return v;
  endfunction

  // Reference decision taken straight from the split/join rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   lanes_then = (v.then_m != 4'd0);
    bit   lanes_else = (v.else_m != 4'd0);
    r.e_push = 0; r.e_pop = 0; r.e_pcv = 0; r.e_pc = '0; r.e_div = 0; r.e_tmask = v.tmask;
    if (v.is_split) begin
      if (lanes_then && lanes_else) begin
        r.e_tmask = v.then_m;
        r.e_push  = !v.full;
        r.e_div   = !v.full;
      end else if (lanes_else) begin
        r.e_tmask = v.else_m;
        r.e_pcv   = 1;
        r.e_pc    = v.else_pc;
      end else if (lanes_then) begin
        r.e_tmask = v.then_m;
      end
      return r;
    end
    if (v.join_ptr == v.q_ptr || v.empty) return r;
    r.e_pop   = 1;
    r.e_tmask = v.stk_d[33:30];
    r.e_pcv   = v.d_set;
    r.e_pc    = v.d_set ? v.stk_d[29:0] : 30'd0;
    return r;
  endfunction

  task automatic driveVec(input vec_t v);
    req_is_split   = v.is_split;
    req_tmask      = v.tmask;
    req_then_tmask = v.then_m;
    req_else_tmask = v.else_m;
    req_else_pc    = v.else_pc;
    req_join_ptr   = v.join_ptr;
    stk_d          = v.stk_d;
    stk_d_set      = v.d_set;
    stk_q_ptr      = v.q_ptr;
    stk_empty      = v.empty;
    stk_full       = v.full;
  endtask

  task automatic checkRsp(input vec_t v, input int d);
    checkOutput($sformatf("%s/d%0d/rsp_valid", v.name, d), 64'(rsp_valid[d]), 64'd1);
    checkOutput($sformatf("%s/d%0d/rsp_tmask", v.name, d), 64'(rsp_tmask[d]), 64'(v.e_tmask));
    checkOutput($sformatf("%s/d%0d/rsp_pc_valid", v.name, d), 64'(rsp_pc_valid[d]), 64'(v.e_pcv));
    checkOutput($sformatf("%s/d%0d/rsp_divergent", v.name, d), 64'(rsp_divergent[d]), 64'(v.e_div));
    if (v.e_pcv)
      checkOutput($sformatf("%s/d%0d/rsp_pc", v.name, d), 64'(rsp_pc[d]), 64'(v.e_pc));
    if (v.is_split)
      checkOutput($sformatf("%s/d%0d/rsp_sptr", v.name, d), 64'(rsp_sptr[d]), 64'(v.q_ptr));
  endtask

  // One request through both instances: stack strobes, response, flags and settle length.
  task automatic applyStimulus(input vec_t v);
    int  low [2];
    bit  seen [2];
    @(negedge clk);
    driveVec(v);
    req_valid = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s/d%0d/ready", v.name, d), 64'(req_ready[d]), 64'd1);
      checkOutput($sformatf("%s/d%0d/stk_push", v.name, d), 64'(stk_push[d]), 64'(v.e_push));
      checkOutput($sformatf("%s/d%0d/stk_pop", v.name, d), 64'(stk_pop[d]), 64'(v.e_pop));
      if (v.e_push) begin
        checkOutput($sformatf("%s/d%0d/stk_q1", v.name, d), 64'(stk_q1[d]), 64'({v.else_m, v.else_pc}));
        checkOutput($sformatf("%s/d%0d/stk_q0", v.name, d), 64'(stk_q0[d]), 64'({v.tmask, 30'd0}));
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (v.is_split && v.then_m != 0 && v.else_m != 0 && v.full) exp_ovf = 1;
    if (!v.is_split && v.join_ptr != v.q_ptr && v.empty) exp_unf = 1;
    if (v.e_push) exp_dvg++;
    if (v.e_pop && v.e_pcv) exp_redir++;
    for (int d = 0; d < 2; d++) begin
      checkRsp(v, d);
      checkOutput($sformatf("%s/d%0d/err_ovf", v.name, d), 64'(err_ovf[d]), 64'(exp_ovf));
      checkOutput($sformatf("%s/d%0d/err_unf", v.name, d), 64'(err_unf[d]), 64'(exp_unf));
      low[d] = 0;
      seen[d] = 0;
    end
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          if (req_ready[d]) seen[d] = 1;
          else low[d]++;
        end
      end
      if (seen[0] && seen[1]) break;
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("%s/d%0d/settle_cycles", v.name, d), 64'(low[d]),
                  64'((v.e_push || v.e_pop) ? (1 + d) : 0));
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("%s/d%0d/rsp_pulse_end", v.name, d), 64'(rsp_valid[d]), 64'd0);
  endtask

  task automatic checkPerf(input string tag);
    int ed;
    int er;
`ifdef IPDOM_PERF_EN
    ed = exp_dvg;
    er = exp_redir;
`else
    ed = 0;
    er = 0;
`endif
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s/d%0d/perf_dvg", tag, d), 64'(perf_dvg_cnt[d]), 64'(ed));
      checkOutput($sformatf("%s/d%0d/perf_redir", tag, d), 64'(perf_redir_cnt[d]), 64'(er));
    end
  endtask

  initial begin
    vec_t v;
    vec_t a;
    vec_t b;

    table_v[0] = mk("split_dvg", 1, 4'hF, 4'h3, 4'hC, 30'h40, 3'd0, 34'd0, 0, 3'd0, 1, 0,
                    1, 0, 4'h3, 0, 30'h0, 1);
    table_v[1] = mk("join_else", 0, 4'h3, 4'h0, 4'h0, 30'h0, 3'd0, {4'hC, 30'h40}, 1, 3'd1, 0, 0,
                    0, 1, 4'hC, 1, 30'h40, 0);
    table_v[2] = mk("join_restore", 0, 4'hC, 4'h0, 4'h0, 30'h0, 3'd0, {4'hF, 30'h0}, 0, 3'd1, 0, 0,
                    0, 1, 4'hF, 0, 30'h0, 0);
    table_v[3] = mk("split_uniform", 1, 4'hF, 4'h0, 4'hF, 30'h80, 3'd0, 34'd0, 0, 3'd0, 1, 0,
                    0, 0, 4'hF, 1, 30'h80, 0);
    table_v[4] = mk("join_match", 0, 4'hF, 4'h0, 4'h0, 30'h0, 3'd0, {4'h5, 30'h99}, 1, 3'd0, 1, 0,
                    0, 0, 4'hF, 0, 30'h0, 0);
    table_v[5] = mk("split_full", 1, 4'hF, 4'h5, 4'hA, 30'h100, 3'd0, 34'd0, 0, 3'd7, 0, 1,
                    0, 0, 4'h5, 0, 30'h0, 0);
    table_v[6] = mk("join_underflow", 0, 4'h6, 4'h0, 4'h0, 30'h0, 3'd3, {4'h9, 30'h7}, 1, 3'd0, 1, 0,
                    0, 0, 4'h6, 0, 30'h0, 0);
    table_v[7] = mk("split_then_only", 1, 4'hF, 4'hF, 4'h0, 30'h123, 3'd2, 34'd0, 0, 3'd2, 0, 0,
                    0, 0, 4'hF, 0, 30'h0, 0);

    reset = 1'b1;
    req_valid = 1'b0;
    driveVec(table_v[0]);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset/d%0d/ready", d), 64'(req_ready[d]), 64'd1);
      checkOutput($sformatf("reset/d%0d/rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      checkOutput($sformatf("reset/d%0d/rsp_tmask", d), 64'(rsp_tmask[d]), 64'd0);
      checkOutput($sformatf("reset/d%0d/err", d), 64'({err_ovf[d], err_unf[d]}), 64'd0);
    end
    checkPerf("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(table_v[i]);
      if (i == 2) checkPerf("after_first_three");
    end

    $display("[TB] back-to-back non-stack requests");
    a = mk("b2b_a", 1, 4'hF, 4'h0, 4'h9, 30'h55, 3'd0, 34'd0, 0, 3'd4, 0, 0, 0, 0, 4'h9, 1, 30'h55, 0);
    b = mk("b2b_b", 0, 4'h7, 4'h0, 4'h0, 30'h0, 3'd4, 34'd0, 0, 3'd4, 0, 0, 0, 0, 4'h7, 0, 30'h0, 0);
    @(negedge clk);
    driveVec(a);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkRsp(a, d);
      checkOutput($sformatf("b2b/d%0d/ready_stays", d), 64'(req_ready[d]), 64'd1);
    end
    @(negedge clk);
    driveVec(b);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int d = 0; d < 2; d++) checkRsp(b, d);

    $display("[TB] randomized requests");
    for (int i = 0; i < 150; i++) begin
      v.name     = $sformatf("rand%0d", i);
      v.is_split = 1'($urandom_range(0, 1));
      v.tmask    = 4'($urandom);
      v.then_m   = 4'($urandom);
      v.else_m   = 4'($urandom);
      v.else_pc  = 30'($urandom);
      v.q_ptr    = 3'($urandom);
      v.join_ptr = ($urandom_range(0, 3) == 0) ? v.q_ptr : 3'($urandom);
      v.stk_d    = {4'($urandom), 30'($urandom)};
      v.d_set    = 1'($urandom_range(0, 1));
      v.empty    = ($urandom_range(0, 5) == 0);
      v.full     = ($urandom_range(0, 5) == 0);
      v = model(v);
      applyStimulus(v);
    end
    checkPerf("after_random");

    $display("[TB] reset during settle");
    @(negedge clk);
    driveVec(table_v[0]);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("midsettle/d%0d/busy", d), 64'(req_ready[d]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_ovf = 0; exp_unf = 0; exp_dvg = 0; exp_redir = 0;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("midsettle/d%0d/ready", d), 64'(req_ready[d]), 64'd1);
      checkOutput($sformatf("midsettle/d%0d/rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      checkOutput($sformatf("midsettle/d%0d/err", d), 64'({err_ovf[d], err_unf[d]}), 64'd0);
    end
    checkPerf("midsettle");

    $display("[TB] request during reset is dropped");
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("inreset/d%0d/stk_push", d), 64'(stk_push[d]), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("inreset/d%0d/rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(table_v[0]);
    checkPerf("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
